dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter: RAM_AW, default 8, width of the data RAM word address (ram_addr).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  1  load/store request present.
REQ-006 req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
REQ-007 req_we  in  1  1=store, 0=load.
REQ-008 req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-010 req_addr  in  32  byte address.
REQ-011 req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 resp_valid  out  1  one-cycle completion pulse.
REQ-013 resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-014 resp_err  out  1  valid with resp_valid; misaligned or illegal size.
REQ-015 ram_addr  out  RAM_AW  word index to data RAM.
REQ-016 ram_we  out  1  data RAM write enable (RAM writes on rising clk).
REQ-017 ram_wdata  out  32  full word written to data RAM.
REQ-018 ram_rdata  in  32  data RAM combinational read data for ram_addr.

Function
REQ-019 FSM states SHALL be IDLE, RD, WR, RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 On acceptance the block SHALL latch we, size, unsigned, addr, wdata; inputs are ignored until the next IDLE.
REQ-021 ram_addr SHALL equal latched addr[RAM_AW+1:2] in RD and WR; 0 in IDLE and RESP.
REQ-022 Error: size=11, half with addr[0]=1, or word with addr[1:0]!=0; IDLE->RESP with resp_err=1, no RAM write.
REQ-023 Load: IDLE->RD->RESP; in RD the block SHALL capture ram_rdata into a 32-bit buffer.
REQ-024 Load result: select byte addr[1:0] (byte lane k = bits 8k+7:8k) or half addr[1] (bits 16h+15:16h), then zero/sign-extend per unsigned; word passes through.
REQ-025 Word store: IDLE->WR->RESP; RD is skipped and ram_wdata = latched wdata.
REQ-026 Sub-word store: IDLE->RD->WR->RESP; in RD capture ram_rdata; in WR ram_wdata = captured word with only the addressed byte/half replaced by wdata[7:0]/[15:0].
REQ-027 ram_we SHALL be 1 exactly during the single WR cycle and 0 in every other state.
REQ-028 resp_valid SHALL be 1 exactly during the single RESP cycle; RESP->IDLE unconditionally (no resp backpressure).
REQ-029 Latency from acceptance edge to resp_valid: error 1 cycle, load 2, word store 2, sub-word store 3.
REQ-030 resp_rdata and resp_err SHALL be 0 whenever resp_valid is 0.
REQ-031 Back-to-back: a request presented during RESP is not accepted until the following IDLE cycle.
REQ-032 Address bits above RAM_AW+1 SHALL be ignored (wrap modulo 2^(RAM_AW+2) bytes), not flagged as errors.

Reset
REQ-033 While rst_n=0: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, ram_we=0, ram_addr=0, ram_wdata=0, buffers cleared.
REQ-034 Reset asserted mid-operation (including WR) SHALL drop ram_we immediately and abort the request with no response.

Verification
REQ-035 RAM word 0x10 = 0x8070_F0AA; LB addr 0x41 signed -> resp at +2 cycles, resp_rdata=0xFFFF_FFF0, resp_err=0.
REQ-036 Same word; LHU addr 0x42 -> resp_rdata=0x0000_8070; LH addr 0x42 -> 0xFFFF_8070.
REQ-037 SB addr 0x43 wdata 0x1234_5655 -> one ram_we pulse at +2, ram_addr=0x10, ram_wdata=0x5570_F0AA, resp at +3.
REQ-038 SW addr 0x40 wdata 0xDEAD_BEEF -> ram_we at +1 with 0xDEAD_BEEF, no RD state, resp at +2.
REQ-039 LW addr 0x42 and SH addr 0x41 -> resp at +1 with resp_err=1, ram_we never asserted.
REQ-040 rst_n low during WR of a SB -> ram_we falls immediately, no resp_valid, RAM word unchanged, req_ready=1 after release.

Source files
------------

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - load/store unit bridging byte/half/word requests onto a word-wide data RAM
// Sub-word stores read-modify-write the addressed word; misaligned or illegal sizes answer with an error.
module dmem_ctrl #(
  parameter int RAM_AW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RESP = 2'd3} state_t;

  state_t              state_q;
  logic                we_q;
  logic                unsigned_q;
  logic [1:0]          size_q;
  logic [1:0]          off_q;
  logic [15:0]         wdata_q;
  logic                req_ready_q;
  logic                resp_valid_q;
  logic                resp_err_q;
  logic [31:0]         resp_rdata_q;
  logic                ram_we_q;
  logic [RAM_AW-1:0]   ram_addr_q;
  logic [31:0]         ram_wdata_q;

  logic                req_err_d;
  logic [7:0]          byte_d;
  logic [15:0]         half_d;
  logic [31:0]         load_d;
  logic [31:0]         merge_d;
  logic                unused_addr_hi;

  // Upper address bits wrap silently rather than faulting.
  assign unused_addr_hi = ^req_addr[31:RAM_AW+2];

  always_comb begin
    req_err_d = 1'b0;
    case (req_size)
      2'b00:   req_err_d = 1'b0;
      2'b01:   req_err_d = req_addr[0];
      2'b10:   req_err_d = |req_addr[1:0];
      default: req_err_d = 1'b1;
    endcase
  end

  always_comb begin
    byte_d  = ram_rdata[{off_q, 3'b000} +: 8];
    half_d  = off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    load_d  = ram_rdata;
    merge_d = ram_rdata;
    case (size_q)
      2'b00:   load_d = {{24{byte_d[7] & ~unsigned_q}}, byte_d};
      2'b01:   load_d = {{16{half_d[15] & ~unsigned_q}}, half_d};
      default: load_d = ram_rdata;
    endcase
    if (size_q == 2'b00) begin
      merge_d[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merge_d[{off_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  // The RD-cycle RAM word is captured straight into resp_rdata_q (loads) or ram_wdata_q (sub-word stores).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      unsigned_q   <= 1'b0;
      size_q       <= 2'b00;
      off_q        <= 2'b00;
      wdata_q      <= 16'h0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            unsigned_q  <= req_unsigned;
            size_q      <= req_size;
            off_q       <= req_addr[1:0];
            wdata_q     <= req_wdata[15:0];
            req_ready_q <= 1'b0;
            if (req_err_d) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'h0;
            end else if (req_we && req_size == 2'b10) begin
              state_q     <= WR;
              ram_we_q    <= 1'b1;
              ram_addr_q  <= req_addr[RAM_AW+1:2];
              ram_wdata_q <= req_wdata;
            end else begin
              state_q    <= RD;
              ram_addr_q <= req_addr[RAM_AW+1:2];
            end
          end
        end
        RD: begin
          if (we_q) begin
            state_q     <= WR;
            ram_we_q    <= 1'b1;
            ram_wdata_q <= merge_d;
          end else begin
            state_q      <= RESP;
            ram_addr_q   <= '0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= load_d;
          end
        end
        WR: begin
          state_q      <= RESP;
          ram_we_q     <= 1'b0;
          ram_addr_q   <= '0;
          ram_wdata_q  <= 32'h0;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'h0;
        end
        default: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'h0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign ram_addr   = ram_addr_q;
  assign ram_we     = ram_we_q;
  assign ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed self-checking bench for dmem_ctrl
// Owns a behavioural data RAM; expected values are hand-computed per scenario.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata, ram_rdata;

  logic [31:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  int          o_resp_cyc, o_resp_cnt, o_we_cnt, o_we_cyc;
  logic [31:0] o_rdata, o_we_data;
  logic [7:0]  o_we_addr;
  logic        o_err, o_leak, o_rdy;

  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;

  dmem_ctrl #(.RAM_AW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Issue one request, then observe 6 cycles (negedge samples); cycle 1 follows the accept edge.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    o_rdy = req_ready;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_size = ~size; req_unsigned = ~uns;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'hA5A5_A5A5;
    o_resp_cyc = 0; o_resp_cnt = 0; o_we_cnt = 0; o_we_cyc = 0;
    o_rdata = 32'h0; o_err = 1'b0; o_leak = 1'b0; o_we_data = 32'h0; o_we_addr = 8'h0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (ram_we) begin
        o_we_cnt++; o_we_cyc = c; o_we_addr = ram_addr; o_we_data = ram_wdata;
      end
      if (resp_valid) begin
        o_resp_cnt++;
        if (o_resp_cyc == 0) begin o_resp_cyc = c; o_rdata = resp_rdata; o_err = resp_err; end
      end else if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
        o_leak = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
    n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", resp_err); end
    n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
    n_checks++; if (ram_addr !== 8'h0) begin n_fail++; $display("FAIL reset_ram_addr got=%h exp=0", ram_addr); end
    n_checks++; if (ram_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_ram_wdata got=%h exp=0", ram_wdata); end
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    logic        v_we   [7];
    logic [1:0]  v_size [7];
    logic        v_uns  [7];
    logic [31:0] v_addr [7];
    logic [31:0] v_exp  [7];
    v_we = '{0, 0, 0, 0, 0, 0, 0};
    v_size = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10};
    v_uns = '{0, 1, 1, 0, 0, 0, 0};
    v_addr = '{32'h41, 32'h40, 32'h42, 32'h42, 32'h40, 32'h40, 32'h1040};
    v_exp = '{32'hFFFF_FFF0, 32'h0000_00AA, 32'h0000_8070, 32'hFFFF_8070,
              32'h8070_F0AA, 32'hFFFF_F0AA, 32'h8070_F0AA};
    for (int i = 0; i < 7; i++) begin
      do_req(v_we[i], v_size[i], v_uns[i], v_addr[i], 32'h0);
      n_checks++; if (o_rdy !== 1'b1) begin n_fail++; $display("FAIL load%0d_ready got=%b exp=1", i, o_rdy); end
      n_checks++; if (o_resp_cyc != 2 || o_resp_cnt != 1) begin n_fail++; $display("FAIL load%0d_latency got=%0d/%0d exp=2/1", i, o_resp_cyc, o_resp_cnt); end
      n_checks++; if (o_rdata !== v_exp[i]) begin n_fail++; $display("FAIL load%0d_rdata got=%h exp=%h", i, o_rdata, v_exp[i]); end
      n_checks++; if (o_err !== 1'b0 || o_we_cnt != 0 || o_leak !== 1'b0) begin n_fail++; $display("FAIL load%0d_side err=%b we=%0d leak=%b exp 0/0/0", i, o_err, o_we_cnt, o_leak); end
    end
  endtask

  task automatic test_store_sub();
    do_req(1'b1, 2'b00, 1'b0, 32'h43, 32'h1234_5655);
    n_checks++; if (o_we_cnt != 1 || o_we_cyc != 2) begin n_fail++; $display("FAIL sb_we got=%0d@%0d exp=1@2", o_we_cnt, o_we_cyc); end
    n_checks++; if (o_we_addr !== 8'h10) begin n_fail++; $display("FAIL sb_addr got=%h exp=10", o_we_addr); end
    n_checks++; if (o_we_data !== 32'h5570_F0AA) begin n_fail++; $display("FAIL sb_wdata got=%h exp=5570f0aa", o_we_data); end
    n_checks++; if (o_resp_cyc != 3 || o_rdata !== 32'h0 || o_err !== 1'b0) begin n_fail++; $display("FAIL sb_resp got=%0d/%h/%b exp=3/0/0", o_resp_cyc, o_rdata, o_err); end
    n_checks++; if (mem[8'h10] !== 32'h5570_F0AA) begin n_fail++; $display("FAIL sb_mem got=%h exp=5570f0aa", mem[8'h10]); end
    do_req(1'b1, 2'b01, 1'b0, 32'h44, 32'h0000_BEEF);
    n_checks++; if (o_we_cnt != 1 || o_we_cyc != 2 || o_we_addr !== 8'h11) begin n_fail++; $display("FAIL sh_we got=%0d@%0d addr=%h exp=1@2 addr=11", o_we_cnt, o_we_cyc, o_we_addr); end
    n_checks++; if (o_we_data !== 32'h1122_BEEF) begin n_fail++; $display("FAIL sh_wdata got=%h exp=1122beef", o_we_data); end
    do_req(1'b1, 2'b01, 1'b0, 32'h46, 32'hFFFF_CAFE);
    n_checks++; if (mem[8'h11] !== 32'hCAFE_BEEF || o_resp_cyc != 3) begin n_fail++; $display("FAIL sh_hi got=%h@%0d exp=cafebeef@3", mem[8'h11], o_resp_cyc); end
  endtask

  task automatic test_store_word();
    do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF);
    n_checks++; if (o_we_cnt != 1 || o_we_cyc != 1 || o_we_addr !== 8'h10) begin n_fail++; $display("FAIL sw_we got=%0d@%0d addr=%h exp=1@1 addr=10", o_we_cnt, o_we_cyc, o_we_addr); end
    n_checks++; if (o_we_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_wdata got=%h exp=deadbeef", o_we_data); end
    n_checks++; if (o_resp_cyc != 2 || o_err !== 1'b0 || o_rdata !== 32'h0) begin n_fail++; $display("FAIL sw_resp got=%0d/%b/%h exp=2/0/0", o_resp_cyc, o_err, o_rdata); end
    do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    n_checks++; if (o_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_readback got=%h exp=deadbeef", o_rdata); end
  endtask

  task automatic test_error();
    logic        v_we   [4];
    logic [1:0]  v_size [4];
    logic [31:0] v_addr [4];
    v_we = '{0, 1, 1, 0};
    v_size = '{2'b10, 2'b01, 2'b11, 2'b01};
    v_addr = '{32'h42, 32'h41, 32'h40, 32'h43};
    for (int i = 0; i < 4; i++) begin
      do_req(v_we[i], v_size[i], 1'b0, v_addr[i], 32'h0BAD_0BAD);
      n_checks++; if (o_resp_cyc != 1 || o_err !== 1'b1 || o_resp_cnt != 1) begin n_fail++; $display("FAIL err%0d_resp got=%0d/%b/%0d exp=1/1/1", i, o_resp_cyc, o_err, o_resp_cnt); end
      n_checks++; if (o_rdata !== 32'h0 || o_we_cnt != 0) begin n_fail++; $display("FAIL err%0d_side rdata=%h we=%0d exp=0/0", i, o_rdata, o_we_cnt); end
    end
    n_checks++; if (mem[8'h10] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL err_mem got=%h exp=deadbeef", mem[8'h10]); end
  endtask

  task automatic test_back_to_back();
    int   resp_at [$];
    logic rdy2, rdy3;
    rdy2 = 1'b1; rdy3 = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h44; req_wdata = 32'h0;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (resp_valid) resp_at.push_back(c);
      if (c == 2) rdy2 = req_ready;
      if (c == 3) rdy3 = req_ready;
      if (c == 5) req_valid = 1'b0;
    end
    n_checks++; if (resp_at.size() != 2) begin n_fail++; $display("FAIL b2b_count got=%0d exp=2", resp_at.size()); end
    else begin
      n_checks++; if (resp_at[0] != 2 || resp_at[1] != 5) begin n_fail++; $display("FAIL b2b_cycles got=%0d,%0d exp=2,5", resp_at[0], resp_at[1]); end
    end
    n_checks++; if (rdy2 !== 1'b0 || rdy3 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready resp=%b idle=%b exp=0/1", rdy2, rdy3); end
  endtask

  task automatic test_reset_mid_wr();
    int   seen_resp;
    logic we_before;
    seen_resp = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h48; req_wdata = 32'h0000_0077;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    we_before = ram_we;
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (we_before !== 1'b1) begin n_fail++; $display("FAIL rst_wr_entered got=%b exp=1", we_before); end
    n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rst_we_drop got=%b exp=0", ram_we); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid) seen_resp++;
    end
    n_checks++; if (seen_resp != 0) begin n_fail++; $display("FAIL rst_no_resp got=%0d exp=0", seen_resp); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
    n_checks++; if (mem[8'h12] !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rst_mem got=%h exp=cafef00d", mem[8'h12]); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'h8070_F0AA;
    mem[8'h11] = 32'h1122_3344;
    mem[8'h12] = 32'hCAFE_F00D;
    test_reset();
    test_load();
    test_store_sub();
    test_store_word();
    test_error();
    test_back_to_back();
    test_reset_mid_wr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
